// File: rtl/ram_wb_packer.sv
// Wishbone 32-bit front end for the 4-bit RAM backdoor: splits each host word
// access into one backdoor access per enabled nibble and reassembles read data.
module ram_wb_packer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        ram_cyc_o,
  output logic        ram_stb_o,
  output logic        ram_we_o,
  output logic [31:0] ram_adr_o,
  output logic [31:0] ram_dat_o,
  input  logic [31:0] ram_dat_i,
  input  logic        ram_ack_i,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic        r_region;
  logic [2:0]  r_word;
  logic [31:0] r_data;
  logic [7:0]  r_mask;
  logic [2:0]  r_idx;
  logic        r_abort;
  logic [31:0] r_dat_o;
  logic        r_ack;
  logic        r_stb;
  logic        r_cyc;
  logic        r_ram_we;
  logic [31:0] r_ram_adr;
  logic [31:0] r_ram_dat;
  logic        r_busy;

  state_t      w_state_nxt;
  logic        w_we_nxt;
  logic        w_region_nxt;
  logic [2:0]  w_word_nxt;
  logic [31:0] w_data_nxt;
  logic [7:0]  w_mask_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_abort_nxt;
  logic [31:0] w_dat_o_nxt;
  logic        w_ack_nxt;
  logic        w_stb_nxt;
  logic        w_ram_we_nxt;
  logic [31:0] w_ram_adr_nxt;
  logic [31:0] w_ram_dat_nxt;
  logic        w_busy_nxt;

  logic [7:0]  w_req_mask;
  logic [2:0]  w_req_idx;
  logic [2:0]  w_req_word;
  logic [2:0]  w_run_idx;
  logic        w_unused;

  // Reads touch every nibble; writes only the nibbles of selected byte lanes.
  function automatic logic [7:0] f_nibble_mask(input logic we, input logic [3:0] sel);
    logic [7:0] m;
    if (we) begin
      m = {sel[3], sel[3], sel[2], sel[2], sel[1], sel[1], sel[0], sel[0]};
    end else begin
      m = 8'hFF;
    end
    return m;
  endfunction

  function automatic logic [2:0] f_lowest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) begin
        r = k[2:0];
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] f_nibble(input logic [31:0] d, input logic [2:0] i);
    logic [31:0] s;
    s = d >> {i, 2'b00};
    return s[3:0];
  endfunction

  // Status words sit above the memory words; only one word bit is decoded there.
  function automatic logic [31:0] f_ram_adr(input logic region, input logic [2:0] word,
                                            input logic [2:0] idx);
    logic [31:0] a;
    if (region) begin
      a = {23'h0, 1'b1, 2'b00, word[0], idx, 2'b00};
    end else begin
      a = {23'h0, 1'b0, word, idx, 2'b00};
    end
    return a;
  endfunction

  assign w_req_mask = f_nibble_mask(wbs_we_i, wbs_sel_i);
  assign w_req_idx  = f_lowest(w_req_mask);
  assign w_req_word = wbs_adr_i[8] ? {2'b00, wbs_adr_i[2]} : wbs_adr_i[4:2];
  assign w_run_idx  = f_lowest(r_mask);
  assign w_unused   = &{1'b0, ram_dat_i[31:4], wbs_adr_i[31:9], wbs_adr_i[1:0]};

  // Next-state and next-output logic for the request sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_we_nxt      = r_we;
    w_region_nxt  = r_region;
    w_word_nxt    = r_word;
    w_data_nxt    = r_data;
    w_mask_nxt    = r_mask;
    w_idx_nxt     = r_idx;
    w_abort_nxt   = r_abort;
    w_dat_o_nxt   = r_dat_o;
    w_ack_nxt     = 1'b0;
    w_stb_nxt     = r_stb;
    w_ram_we_nxt  = r_ram_we;
    w_ram_adr_nxt = r_ram_adr;
    w_ram_dat_nxt = r_ram_dat;
    case (r_state)
      ST_IDLE: begin
        w_abort_nxt = 1'b0;
        if (wbs_cyc_i && wbs_stb_i && !r_ack) begin
          w_we_nxt     = wbs_we_i;
          w_region_nxt = wbs_adr_i[8];
          w_word_nxt   = w_req_word;
          w_data_nxt   = wbs_dat_i;
          w_dat_o_nxt  = 32'h0;
          if (w_req_mask == 8'h00) begin
            w_state_nxt = ST_ACK;
            w_mask_nxt  = 8'h00;
          end else begin
            w_state_nxt   = ST_RUN;
            w_idx_nxt     = w_req_idx;
            w_mask_nxt    = w_req_mask & (w_req_mask - 8'd1);
            w_stb_nxt     = 1'b1;
            w_ram_we_nxt  = wbs_we_i;
            w_ram_adr_nxt = f_ram_adr(wbs_adr_i[8], w_req_word, w_req_idx);
            w_ram_dat_nxt = {28'h0, f_nibble(wbs_dat_i, w_req_idx)};
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!wbs_cyc_i) begin
          w_abort_nxt = 1'b1;
        end else begin
          w_abort_nxt = r_abort;
        end
        if (ram_ack_i) begin
          if (!r_we) begin
            w_dat_o_nxt[{r_idx, 2'b00} +: 4] = ram_dat_i[3:0];
          end else begin
            w_dat_o_nxt = r_dat_o;
          end
          // r_mask holds the enabled nibbles still to issue after the current one.
          if (r_abort || !wbs_cyc_i) begin
            w_state_nxt = ST_IDLE;
            w_stb_nxt   = 1'b0;
            w_mask_nxt  = 8'h00;
            w_abort_nxt = 1'b0;
          end else if (r_mask == 8'h00) begin
            w_state_nxt = ST_ACK;
            w_stb_nxt   = 1'b0;
          end else begin
            w_idx_nxt     = w_run_idx;
            w_mask_nxt    = r_mask & (r_mask - 8'd1);
            w_ram_adr_nxt = f_ram_adr(r_region, r_word, w_run_idx);
            w_ram_dat_nxt = {28'h0, f_nibble(r_data, w_run_idx)};
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_ACK: begin
        w_ack_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_stb_nxt   = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_region  <= 1'b0;
      r_word    <= 3'd0;
      r_data    <= 32'h0;
      r_mask    <= 8'h00;
      r_idx     <= 3'd0;
      r_abort   <= 1'b0;
      r_dat_o   <= 32'h0;
      r_ack     <= 1'b0;
      r_stb     <= 1'b0;
      r_cyc     <= 1'b0;
      r_ram_we  <= 1'b0;
      r_ram_adr <= 32'h0;
      r_ram_dat <= 32'h0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_we      <= w_we_nxt;
      r_region  <= w_region_nxt;
      r_word    <= w_word_nxt;
      r_data    <= w_data_nxt;
      r_mask    <= w_mask_nxt;
      r_idx     <= w_idx_nxt;
      r_abort   <= w_abort_nxt;
      r_dat_o   <= w_dat_o_nxt;
      r_ack     <= w_ack_nxt;
      r_stb     <= w_stb_nxt;
      r_cyc     <= w_stb_nxt;
      r_ram_we  <= w_ram_we_nxt;
      r_ram_adr <= w_ram_adr_nxt;
      r_ram_dat <= w_ram_dat_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign wbs_dat_o = r_dat_o;
  assign wbs_ack_o = r_ack;
  assign ram_cyc_o = r_cyc;
  assign ram_stb_o = r_stb;
  assign ram_we_o  = r_ram_we;
  assign ram_adr_o = r_ram_adr;
  assign ram_dat_o = r_ram_dat;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ram_wb_packer.sv
// Bench for ram_wb_packer: a nibble RAM responder granting one access per
// 8-clock cycle, and a word-level model of memory/status contents.
module tb_ram_wb_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        ram_cyc_o, ram_stb_o, ram_we_o;
  logic [31:0] ram_adr_o, ram_dat_o;
  logic [31:0] ram_dat_i = 32'h0;
  logic        ram_ack_i = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  ram_wb_packer dut (
    .clock(clock), .reset_n(reset_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .ram_cyc_o(ram_cyc_o), .ram_stb_o(ram_stb_o), .ram_we_o(ram_we_o),
    .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o),
    .ram_dat_i(ram_dat_i), .ram_ack_i(ram_ack_i), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Backdoor RAM: 128 nibble cells, acks on the last clock of each 8-clock cycle.
  logic [3:0]  ram_mem [128];
  logic [31:0] acc_adr[$];
  logic [31:0] acc_dat[$];
  logic        acc_we[$];
  int          acc_cyc[$];
  int          phase = 0;
  logic        stray_ack = 1'b0;

  initial for (int i = 0; i < 128; i++) ram_mem[i] = 4'h0;

  always @(negedge clock) begin
    logic [31:0] rnd;
    phase = (phase + 1) % 8;
    ram_ack_i = 1'b0;
    rnd = $urandom;
    if (stray_ack) begin
      ram_ack_i = 1'b1;
      ram_dat_i = rnd;
    end else if (ram_stb_o && ram_cyc_o && phase == 7) begin
      ram_ack_i = 1'b1;
      if (ram_we_o) ram_mem[ram_adr_o[8:2]] = ram_dat_o[3:0];
      ram_dat_i = {rnd[31:4], ram_mem[ram_adr_o[8:2]]};
      acc_adr.push_back(ram_adr_o);
      acc_dat.push_back(ram_dat_o);
      acc_we.push_back(ram_we_o);
      acc_cyc.push_back(cyc_cnt);
    end
  end

  // Word-level reference: what the host should read back.
  logic [31:0] exp_mem [8];
  logic [31:0] exp_stat[2];
  initial begin
    for (int i = 0; i < 8; i++) exp_mem[i] = 32'h0;
    exp_stat[0] = 32'h0;
    exp_stat[1] = 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    if (adr[8]) return exp_stat[adr[2]];
    else return exp_mem[adr[4:2]];
  endfunction

  function automatic logic [31:0] exp_bd_adr(input logic [31:0] adr, input int nib);
    if (adr[8]) return 32'h100 + 32'(adr[2]) * 32'h20 + 32'(nib) * 32'd4;
    else return 32'(adr[4:2]) * 32'h20 + 32'(nib) * 32'd4;
  endfunction

  // One host cycle; lat counts negedges from driving the request to seeing ack.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd, output int lat,
                     output logic got);
    @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = 0; got = 1'b0; rd = 32'h0;
    while (!got && lat < 200) begin
      @(negedge clock);
      lat++;
      if (wbs_ack_o) begin
        got = 1'b1;
        rd = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  // Full transaction check against the model: backdoor sequence, latency, data.
  task automatic do_check(input string tag, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd, expw, neww;
    int lat, base, n, k;
    logic got;
    int nibs[$];
    nibs = {};
    for (int i = 0; i < 8; i++) if (!we || sel[i/2]) nibs.push_back(i);
    n = nibs.size();
    expw = model_read(adr);
    base = acc_adr.size();
    txn(we, adr, dat, sel, rd, lat, got);
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(lat <= 8 * n + 2), 32'd1);
    chk({tag, "_nacc"}, 32'(acc_adr.size() - base), 32'(n));
    k = 0;
    foreach (nibs[j]) begin
      if (base + j < acc_adr.size()) begin
        chk({tag, "_adr"}, acc_adr[base + j], exp_bd_adr(adr, nibs[j]));
        chk({tag, "_we"}, 32'(acc_we[base + j]), 32'(we));
        if (we) chk({tag, "_wdat"}, acc_dat[base + j], 32'((dat >> (4 * nibs[j])) & 32'hF));
      end
      k++;
    end
    if (we) begin
      chk({tag, "_rd0"}, rd, 32'h0);
      neww = expw;
      for (int i = 0; i < 8; i++) if (sel[i/2]) neww[4*i +: 4] = dat[4*i +: 4];
      if (adr[8]) exp_stat[adr[2]] = neww;
      else exp_mem[adr[4:2]] = neww;
    end else begin
      chk({tag, "_rdata"}, rd, expw);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int lat, base, cnt;
    logic got, ack_seen;
    logic [31:0] radr, rdat;
    logic [3:0] rsel;

    repeat (3) @(negedge clock);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dato", wbs_dat_o, 32'h0);
    chk("rst_stbcyc", {30'd0, ram_stb_o, ram_cyc_o}, 32'd0);
    chk("rst_we_busy", {30'd0, ram_we_o, busy}, 32'd0);
    chk("rst_adr", ram_adr_o, 32'h0);
    chk("rst_rdat", ram_dat_o, 32'h0);
    reset_n = 1'b1;

    base = acc_adr.size();
    do_check("full_wr", 1'b1, 32'h0C, 32'h87654321, 4'hF);
    for (int j = 1; j < 8; j++)
      if (base + j < acc_cyc.size())
        chk("full_spacing", 32'(acc_cyc[base + j] - acc_cyc[base + j - 1]), 32'd8);
    do_check("full_rd", 1'b0, 32'h0C, 32'h0, 4'hF);

    do_check("stat_wr", 1'b1, 32'h104, 32'hFEDCBA98, 4'hF);
    do_check("stat_rd", 1'b0, 32'h104, 32'h0, 4'hF);
    do_check("stat0_rd", 1'b0, 32'h100, 32'h0, 4'hF);
    do_check("stat_alias", 1'b0, 32'h11C, 32'h0, 4'hF);

    do_check("part_wr", 1'b1, 32'h00, 32'h0000AB00, 4'h2);
    do_check("part_rd", 1'b0, 32'h00, 32'h0, 4'hF);

    base = acc_adr.size();
    txn(1'b1, 32'h08, 32'hDEADBEEF, 4'h0, rd, lat, got);
    chk("empty_lat", 32'(lat), 32'd2);
    chk("empty_nacc", 32'(acc_adr.size() - base), 32'd0);
    chk("empty_rd0", rd, 32'h0);

    // Host drops cyc after the 3rd backdoor ack of a read of word 3.
    base = acc_adr.size();
    @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h0C; wbs_sel_i = 4'hF;
    cnt = 0;
    while (acc_adr.size() < base + 3 && cnt < 100) begin
      @(negedge clock);
      cnt++;
    end
    chk("abort_reach3", 32'(acc_adr.size() >= base + 3), 32'd1);
    @(negedge clock);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    ack_seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (wbs_ack_o) ack_seen = 1'b1;
    end
    chk("abort_nacc", 32'(acc_adr.size() - base), 32'd4);
    if (acc_adr.size() >= base + 4) chk("abort_adr4", acc_adr[base + 3], 32'h6C);
    chk("abort_noack", 32'(ack_seen), 32'd0);
    chk("abort_stb", 32'(ram_stb_o), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    do_check("post_abort", 1'b0, 32'h0C, 32'h0, 4'hF);

    // Reset pulse in the middle of a read of status word 1.
    base = acc_adr.size();
    @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h104; wbs_sel_i = 4'hF;
    cnt = 0;
    while (acc_adr.size() < base + 2 && cnt < 100) begin
      @(negedge clock);
      cnt++;
    end
    repeat (3) @(negedge clock);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("mrst_stb", {30'd0, ram_stb_o, ram_cyc_o}, 32'd0);
    chk("mrst_dato", wbs_dat_o, 32'h0);
    chk("mrst_adr", ram_adr_o, 32'h0);
    chk("mrst_rdat", ram_dat_o, 32'h0);
    chk("mrst_misc", {29'd0, wbs_ack_o, ram_we_o, busy}, 32'd0);
    stray_ack = 1'b1;
    @(negedge clock);
    stray_ack = 1'b0;
    ack_seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (wbs_ack_o || ram_stb_o || busy) ack_seen = 1'b1;
    end
    chk("stray_ignored", 32'(ack_seen), 32'd0);
    chk("stray_dato", wbs_dat_o, 32'h0);
    do_check("post_rst", 1'b0, 32'h104, 32'h0, 4'hF);

    for (int t = 0; t < 40; t++) begin
      radr = $urandom;
      rdat = $urandom;
      rsel = 4'($urandom_range(0, 15));
      do_check("rand", 1'($urandom_range(0, 1)), radr, rdat, rsel);
    end
    for (int w = 0; w < 8; w++) do_check("final_mem", 1'b0, 32'(w * 4), 32'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_wb_packer.md
# ram_wb_packer

Word-wide Wishbone front end for the 4-bit RAM chip's backdoor port. It accepts classic 32-bit Wishbone cycles from the host bus and sequences them into one 4-bit backdoor access per nibble, eight per word. The backdoor services at most one access per 8-clock instruction cycle, so this block owns the whole multi-access sequence. It sits between the host/management Wishbone bus and the RAM's `wb_*` backdoor.

## Interface
- None. Geometry is fixed: 8 memory words, 2 status words, 8 nibbles per word.

- `clock`  in  1  system clock, shared with the RAM.
- `reset_n`  in  1  synchronous reset, active-low.
- `wbs_cyc_i`  in  1  host cycle.
- `wbs_stb_i`  in  1  host strobe.
- `wbs_we_i`  in  1  host write enable.
- `wbs_sel_i`  in  4  host byte lanes. Lane k covers nibbles 2k and 2k+1.
- `wbs_adr_i`  in  32  host byte address. Bit 8 is region (0 = memory, 1 = status). Bits 4:2 are the memory word. Bit 2 is the status word.
- `wbs_dat_i`  in  32  host write data. Nibble i is bits 4i+3:4i.
- `wbs_dat_o`  out  32  assembled read data.
- `wbs_ack_o`  out  1  host acknowledge, one clock wide.
- `ram_cyc_o`, `ram_stb_o`  out  1  backdoor request. Both are always driven equal.
- `ram_we_o`  out  1  backdoor write.
- `ram_adr_o`  out  32  backdoor nibble address.
- `ram_dat_o`  out  32  `{28'h0, nibble}`.
- `ram_dat_i`  in  32  backdoor read data. Only bits 3:0 are used.
- `ram_ack_i`  in  1  backdoor acknowledge, one clock wide.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset values.** `wbs_ack_o`=0, `wbs_dat_o`=0, `ram_cyc_o`=`ram_stb_o`=`ram_we_o`=0, `ram_adr_o`=0, `ram_dat_o`=0, `busy`=0. The FSM goes to IDLE.
- **FSM states:** IDLE, RUN, ACK.
- **IDLE.**
  - A request is accepted when `wbs_cyc_i & wbs_stb_i & !wbs_ack_o`.
  - On accept, the block latches address, we, sel and data, and clears `wbs_dat_o` to 0.
  - It then builds the nibble mask. Reads enable all 8 nibbles. Writes enable nibble i when `sel[i/2]` is set.
  - If the mask is empty, go to ACK. Otherwise load the index with the lowest enabled nibble, raise `ram_stb_o`, and go to RUN.
- **Backdoor addressing.**
  - Memory: `ram_adr_o = {23'h0, 1'b0, word[2:0], idx[2:0], 2'b00}`. `wbs_adr_i[7:5]` is ignored.
  - Status: `ram_adr_o = {23'h0, 1'b1, 2'b00, word, idx[2:0], 2'b00}`. `wbs_adr_i[4:3]` is ignored (aliased).
- **RUN.**
  - `ram_stb_o` stays high until `ram_ack_i`.
  - On `ram_ack_i` for a read, store `ram_dat_i[3:0]` into nibble idx of `wbs_dat_o`.
  - Then advance to the next enabled nibble, updating `ram_adr_o` and `ram_dat_o` in the same clock with `ram_stb_o` held high.
  - After the last enabled nibble, drop `ram_stb_o` and go to ACK.
- **ACK.** Pulse `wbs_ack_o` for one clock, then go to IDLE. A new host request cannot be accepted in the clock where `wbs_ack_o`=1.
- **Host abort.** If `wbs_cyc_i` falls during RUN, set an abort flag. The in-flight nibble completes (stb held until its ack). The block then drops stb and returns to IDLE with no `wbs_ack_o`.
- **Ignored acks.** A `ram_ack_i` seen in IDLE or ACK is ignored.
- **Write data.** Write data is never returned: `wbs_dat_o` reads 0 after a write.

## Timing
- **Issue.** The first backdoor request is issued one clock after accept.
- **Per-nibble cost.** The backdoor grants one nibble per 8-clock instruction cycle. Back-to-back nibbles are therefore exactly 8 clocks apart, because the next request is presented on the ack clock.
- **Full word.** A full-word transaction takes at most 1 + 8×8 + 1 = 66 clocks from accept to `wbs_ack_o`.
- **Partial write.** A partial write with n enabled nibbles takes at most 1 + 8n + 1 clocks.
- **Empty write.** A write with sel=0000 acks 1 clock after accept, with no backdoor activity.
- **Reset mid-operation.** All state clears on the next clock edge and stb drops at once. A late `ram_ack_i` from the aborted nibble is ignored.

## Test plan
- **Full-word write and readback.** Write memory word 3 (adr 0x0C) with 0x87654321, sel=1111.
  - Expect 8 backdoor writes at adr 0x60, 0x64, …, 0x7C with data 1, 2, …, 8, spaced 8 clocks apart, and one `wbs_ack_o`.
  - A read of 0x0C then returns 0x87654321.
- **Status word.** Write status word 1 (adr 0x104) with 0xFEDCBA98, then read it.
  - Expect backdoor adr 0x120..0x13C with bit 8 set.
  - The read returns 0xFEDCBA98. Status word 0 is unchanged.
- **Partial write.** Write memory word 0 with sel=0010, data 0x0000AB00.
  - Expect only 2 backdoor writes: adr 0x08 data 0xB and adr 0x0C data 0xA.
  - Readback shows only nibbles 2 and 3 changed.
- **Empty write.** Write with sel=0000.
  - Expect `wbs_ack_o` exactly 2 clocks after `wbs_stb_i` is first sampled, and `ram_stb_o` never asserted.
- **Host abort.** Drop `wbs_cyc_i` after the 3rd backdoor ack of a read.
  - Expect the 4th nibble to complete, then `ram_stb_o` low, no `wbs_ack_o`, and `busy`=0.
  - The next request is serviced normally.
- **Reset mid-operation.** Assert `reset_n`=0 for one clock mid-RUN.
  - Expect all outputs at reset values on the next clock, and an injected stray `ram_ack_i` to be ignored.
